cut_sequencer: RTL and testbench
================================

Name: cut_sequencer

Overview:
- Top-level sequencer for the cutting station.
- Alternates a feed motor (advance ingredient one slice pitch) with the cut stepper driver (one full chop stroke) for a requested number of slices.
- Sits between the kitchen-helper main controller and the cut/feed motor drivers. It owns the cut driver's enable and consumes its stroke-complete flag.
- Provides settle delay, per-phase watchdog, abort and a done pulse.

Parameters:
- CNT_W, 6, width of slice count request/counter (max 63 slices).
- SETTLE_CYCLES, 25000, clk cycles to wait after feed completes before cutting (0.5 ms at 50 MHz). Must be >= 1.
- TIMEOUT_CYCLES, 50000000, maximum clk cycles allowed in FEED or CUT before the sequencer faults (1 s). Must be >= 2.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  synchronous active-high reset
- start_i  input  1  single-cycle request to begin a job; sampled only in IDLE
- num_cuts_i  input  CNT_W  slices requested; latched on accepted start_i
- abort_i  input  1  abandon the job; also clears a fault
- feed_o  output  1  enable to feed driver; held high for the whole FEED phase
- feed_done_i  input  1  feed driver reports pitch advanced; level, already in clk domain
- cut_o  output  1  enable to cut stepper driver (its cut_i); held high for the whole CUT phase
- cut_end_i  input  1  stroke complete from cut driver (its cut_end_o); produced in the slow divided clock domain, high for many clk cycles
- busy_o  output  1  high in any state except IDLE and ERROR
- done_o  output  1  one-cycle pulse on job completion
- err_o  output  1  high while in ERROR
- cut_cnt_o  output  CNT_W  slices completed in current/last job

Behaviour:
Interface
- One clock; reset is synchronous and active-high.
- Ports are named clk and rst.

Reset
- rst high at a clk edge forces state IDLE.
- All outputs are 0 after that edge: feed_o, cut_o, busy_o, done_o, err_o, cut_cnt_o.
- Also cleared: target register, phase timer, cut_end history register.
- Reset mid-job is immediate; no done_o pulse.

Synchronisation
- cut_end_i passes through a 2-flop synchroniser; a third flop holds the history.
- A stroke event is synchronised-high AND history-low (rising edge). Detection latency is 2 cycles from cut_end_i rising.
- A level already high on entry to CUT is not an event.

States and transitions (all registered; outputs are Moore, decoded from state)
- IDLE
  - start_i=1 and num_cuts_i!=0: latch target=num_cuts_i, clear cut_cnt_o, go to FEED.
  - start_i=1 and num_cuts_i=0: done_o pulses next cycle, stay IDLE, cut_cnt_o cleared.
- FEED
  - feed_o=1.
  - feed_done_i=1: go to SETTLE and clear timer.
- SETTLE
  - Both enables low.
  - Timer counts 0..SETTLE_CYCLES-1, then go to CUT.
  - Exactly SETTLE_CYCLES cycles are spent in SETTLE.
- CUT
  - cut_o=1.
  - On a stroke event, increment cut_cnt_o.
  - If new count == target, go to DONE; otherwise go to FEED.
- DONE
  - done_o=1 for exactly one cycle, then IDLE.
  - cut_cnt_o keeps the final value until the next accepted start.
- ERROR
  - Entered when the timer reaches TIMEOUT_CYCLES-1 in FEED or CUT without the exit condition.
  - Enables low, err_o=1, cut_cnt_o frozen.
  - Leaves only on abort_i (to IDLE) or rst.

Timer rules
- Phase timer is 32 bits, cleared on every state change, saturating.
- If the exit condition and the timeout coincide in the same cycle, the exit condition wins.

Priority and ignored inputs (rst > abort_i > normal transitions)
- abort_i in any non-IDLE state goes to IDLE at the next edge with enables low. No done_o; cut_cnt_o holds the partial count.
- start_i outside IDLE is ignored, including in DONE.
- num_cuts_i changes after latch have no effect.

Latency
- Accepted start at edge N: feed_o high from edge N+1.
- feed_done_i high at edge M: feed_o low from M+1, cut_o high from M+1+SETTLE_CYCLES.
- Final stroke event: cut_o low and done_o high on the same following cycle.

Cut driver ordering
- cut_o deasserts on the event cycle, so the cut driver sees enable low and returns to its rest phase before the next FEED.

Test Plan:
1. SETTLE_CYCLES=4, TIMEOUT=1000; start_i with num_cuts_i=3; feed_done_i 5 cycles after each feed_o rise; cut_end_i pulse 20 cycles after each cut_o rise -> 3 FEED/SETTLE/CUT rounds; cut_o rises exactly 4 cycles after each feed_o fall; done_o single pulse; cut_cnt_o=3; busy_o low next cycle.
2. start_i with num_cuts_i=0 -> no feed_o/cut_o activity; done_o pulse on next cycle; cut_cnt_o=0.
3. cut_end_i held high from before CUT entry, with a low gap then re-rise -> counted once only, at the re-rise (+2 cycles); held level without a new edge never counted.
4. TIMEOUT=100; feed_done_i never asserted -> err_o=1 after exactly 100 cycles in FEED, feed_o low; start_i ignored; abort_i -> IDLE, err_o=0.
5. Job num_cuts_i=5, abort_i during the 3rd CUT -> cut_o low next edge, cut_cnt_o=2, no done_o; new start_i then runs normally from count 0.
6. rst asserted mid-SETTLE, and start_i pulsed while busy -> all outputs 0 after the rst edge; the busy-time start does not extend or restart the job.

Source files
------------

// File: rtl/cut_sequencer.sv
// Cutting-station sequencer: for each requested slice it runs the feed
// motor for one pitch, waits for the ingredient to settle, then enables
// the cut stepper for one full chop stroke. A per-phase watchdog traps
// stalled drives in ERROR; abort_i abandons a job or clears a fault.
module cut_sequencer #(
   parameter int CNT_W          = 6,
   parameter int SETTLE_CYCLES  = 25000,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [CNT_W-1:0] num_cuts_i,
   input  logic             abort_i,
   output logic             feed_o,
   input  logic             feed_done_i,
   output logic             cut_o,
   input  logic             cut_end_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] cut_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FEED,
      S_SETTLE,
      S_CUT,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] TIMER_MAX    = 32'hFFFF_FFFF;

   // State and datapath registers
   state_t           r_state;
   logic [CNT_W-1:0] r_target;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_timer;

   // cut_end_i crosses in from the divided stepper clock
   logic r_sync1;
   logic r_sync2;
   logic r_hist;

   // Registered Moore outputs
   logic r_feed;
   logic r_cut;
   logic r_busy;
   logic r_done;
   logic r_err;

   // Next-state values
   state_t           w_next_state;
   logic [CNT_W-1:0] w_next_target;
   logic [CNT_W-1:0] w_next_cnt;
   logic [31:0]      w_next_timer;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_zero_done;
   logic             w_stroke;
   logic             w_timed_out;

   // A stroke is a fresh rising edge of the synchronised flag; a level that
   // was already high before CUT was entered has had its edge consumed.
   assign w_stroke    = r_sync2 & ~r_hist;
   assign w_cnt_inc   = r_cnt + CNT_W'(1);
   assign w_timed_out = (r_timer == TIMEOUT_LAST);

   // Next-state, counter and target decode
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      w_next_state  = r_state;
      w_next_target = r_target;
      w_next_cnt    = r_cnt;
      w_zero_done   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_next_cnt = '0;
               if (num_cuts_i != '0) begin
                  w_next_target = num_cuts_i;
                  w_next_state  = S_FEED;
               end else begin
                  // Empty job: report completion without leaving IDLE
                  w_zero_done = 1'b1;
               end
            end
         end
         S_FEED: begin
            if (abort_i)          w_next_state = S_IDLE;
            else if (feed_done_i) w_next_state = S_SETTLE;
            else if (w_timed_out) w_next_state = S_ERROR;
         end
         S_SETTLE: begin
            if (abort_i)                     w_next_state = S_IDLE;
            else if (r_timer == SETTLE_LAST) w_next_state = S_CUT;
         end
         S_CUT: begin
            if (abort_i) begin
               w_next_state = S_IDLE;
            end else if (w_stroke) begin
               w_next_cnt   = w_cnt_inc;
               w_next_state = (w_cnt_inc == r_target) ? S_DONE : S_FEED;
            end else if (w_timed_out) begin
               w_next_state = S_ERROR;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         S_ERROR: begin
            if (abort_i) w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Phase timer: zero on every state change, saturating count while timed
   always_comb begin
      w_next_timer = '0;
      if (w_next_state == r_state &&
          (r_state == S_FEED || r_state == S_SETTLE || r_state == S_CUT)) begin
         w_next_timer = (r_timer == TIMER_MAX) ? r_timer : r_timer + 32'd1;
      end
   end

   // State, datapath, synchroniser and registered output update
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it is an ordinary branch inside the
      // clocked block and clk alone sits in the sensitivity list.
      if (rst) begin
         r_state  <= S_IDLE;
         r_target <= '0;
         r_cnt    <= '0;
         r_timer  <= '0;
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_hist   <= 1'b0;
         r_feed   <= 1'b0;
         r_cut    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register here sample
         // the pre-edge values, so the synchroniser chain shifts one stage
         // per clock instead of collapsing into a single flop.
         r_state  <= w_next_state;
         r_target <= w_next_target;
         r_cnt    <= w_next_cnt;
         r_timer  <= w_next_timer;
         r_sync1  <= cut_end_i;
         r_sync2  <= r_sync1;
         r_hist   <= r_sync2;
         r_feed   <= (w_next_state == S_FEED);
         r_cut    <= (w_next_state == S_CUT);
         r_busy   <= (w_next_state != S_IDLE) && (w_next_state != S_ERROR);
         r_done   <= (w_next_state == S_DONE) || w_zero_done;
         r_err    <= (w_next_state == S_ERROR);
      end
   end

   assign feed_o    = r_feed;
   assign cut_o     = r_cut;
   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign err_o     = r_err;
   assign cut_cnt_o = r_cnt;

endmodule

// File: tb/tb_cut_sequencer.sv
// Directed bench for cut_sequencer with a short settle (4) and watchdog
// (100) so every phase boundary can be walked cycle by cycle.
module tb_cut_sequencer;

   localparam int CNT_W = 6;

   logic             clk;
   logic             rst;
   logic             start_i;
   logic [CNT_W-1:0] num_cuts_i;
   logic             abort_i;
   logic             feed_o;
   logic             feed_done_i;
   logic             cut_o;
   logic             cut_end_i;
   logic             busy_o;
   logic             done_o;
   logic             err_o;
   logic [CNT_W-1:0] cut_cnt_o;

   int checks;
   int failures;

   cut_sequencer #(
      .CNT_W         (CNT_W),
      .SETTLE_CYCLES (4),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .num_cuts_i (num_cuts_i),
      .abort_i    (abort_i),
      .feed_o     (feed_o),
      .feed_done_i(feed_done_i),
      .cut_o      (cut_o),
      .cut_end_i  (cut_end_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .cut_cnt_o  (cut_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed output bundle: {feed, cut, busy, done, err, cnt}
   function automatic logic [10:0] outs();
      return {feed_o, cut_o, busy_o, done_o, err_o, cut_cnt_o};
   endfunction

   function automatic logic [10:0] mk(input logic f, input logic c,
                                      input logic b, input logic d,
                                      input logic e, input logic [5:0] n);
      return {f, c, b, d, e, n};
   endfunction

   // Advance one clock; inputs change and outputs are observed 1 ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_feed(input int n);
      repeat (n) tick();
      feed_done_i = 1'b1;
      tick();
      feed_done_i = 1'b0;
   endtask

   task automatic wait_cut(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cut_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Stroke flag high long enough for the 2-flop sync plus the FSM edge
   task automatic stroke();
      cut_end_i = 1'b1;
      repeat (3) tick();
      cut_end_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] exp;
      rst = 1'b1; start_i = 1'b0; num_cuts_i = '0; abort_i = 1'b0;
      feed_done_i = 1'b0; cut_end_i = 1'b0;
      tick(); tick();
      exp = mk(0, 0, 0, 0, 0, 6'd0);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL reset_outs got=%b exp=%b", outs(), exp);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL reset_release got=%b exp=%b", outs(), exp);
      end
   endtask

   task automatic test_full_job();
      logic [10:0] exp;
      num_cuts_i = 6'd3; start_i = 1'b1;
      tick();
      start_i = 1'b0; num_cuts_i = 6'd0;
      exp = mk(1, 0, 1, 0, 0, 6'd0);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t1_start got=%b exp=%b", outs(), exp);
      end
      for (int r = 0; r < 3; r++) begin
         repeat (4) tick();
         exp = mk(1, 0, 1, 0, 0, 6'(r));
         checks++;
         if (outs() !== exp) begin
            failures++; $display("FAIL t1_feed_hold r=%0d got=%b exp=%b", r, outs(), exp);
         end
         feed_done_i = 1'b1;
         tick();
         feed_done_i = 1'b0;
         exp = mk(0, 0, 1, 0, 0, 6'(r));
         checks++;
         if (outs() !== exp) begin
            failures++; $display("FAIL t1_settle r=%0d got=%b exp=%b", r, outs(), exp);
         end
         repeat (3) tick();
         checks++;
         if (outs() !== exp) begin
            failures++; $display("FAIL t1_settle_end r=%0d got=%b exp=%b", r, outs(), exp);
         end
         tick();
         exp = mk(0, 1, 1, 0, 0, 6'(r));
         checks++;
         if (outs() !== exp) begin
            failures++; $display("FAIL t1_cut_rise r=%0d got=%b exp=%b", r, outs(), exp);
         end
         repeat (19) tick();
         cut_end_i = 1'b1;
         tick(); tick();
         checks++;
         if (outs() !== exp) begin
            failures++; $display("FAIL t1_pre_event r=%0d got=%b exp=%b", r, outs(), exp);
         end
         tick();
         cut_end_i = 1'b0;
         if (r < 2) exp = mk(1, 0, 1, 0, 0, 6'(r + 1));
         else       exp = mk(0, 0, 1, 1, 0, 6'd3);
         checks++;
         if (outs() !== exp) begin
            failures++; $display("FAIL t1_stroke r=%0d got=%b exp=%b", r, outs(), exp);
         end
      end
      tick();
      exp = mk(0, 0, 0, 0, 0, 6'd3);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t1_idle got=%b exp=%b", outs(), exp);
      end
      tick();
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t1_single_done got=%b exp=%b", outs(), exp);
      end
   endtask

   task automatic test_zero_job();
      logic [10:0] exp;
      num_cuts_i = 6'd0; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      exp = mk(0, 0, 0, 1, 0, 6'd0);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t2_done got=%b exp=%b", outs(), exp);
      end
      tick();
      exp = mk(0, 0, 0, 0, 0, 6'd0);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t2_idle got=%b exp=%b", outs(), exp);
      end
      repeat (5) tick();
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t2_quiet got=%b exp=%b", outs(), exp);
      end
   endtask

   task automatic test_level_cut_end();
      logic [10:0] exp;
      num_cuts_i = 6'd1; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      cut_end_i = 1'b1;
      repeat (4) tick();
      run_feed(0);
      repeat (4) tick();
      exp = mk(0, 1, 1, 0, 0, 6'd0);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t3_cut got=%b exp=%b", outs(), exp);
      end
      repeat (10) tick();
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t3_level_ignored got=%b exp=%b", outs(), exp);
      end
      cut_end_i = 1'b0;
      repeat (3) tick();
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t3_gap got=%b exp=%b", outs(), exp);
      end
      cut_end_i = 1'b1;
      tick(); tick();
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t3_pre_edge got=%b exp=%b", outs(), exp);
      end
      tick();
      exp = mk(0, 0, 1, 1, 0, 6'd1);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t3_counted got=%b exp=%b", outs(), exp);
      end
      // start_i while in DONE must be ignored
      start_i = 1'b1; num_cuts_i = 6'd2;
      tick();
      start_i = 1'b0;
      cut_end_i = 1'b0;
      exp = mk(0, 0, 0, 0, 0, 6'd1);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t3_start_in_done got=%b exp=%b", outs(), exp);
      end
      tick();
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t3_still_idle got=%b exp=%b", outs(), exp);
      end
   endtask

   task automatic test_timeout();
      logic [10:0] exp;
      num_cuts_i = 6'd2; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (98) tick();
      exp = mk(1, 0, 1, 0, 0, 6'd0);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t4_feed_99 got=%b exp=%b", outs(), exp);
      end
      tick();
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t4_feed_100 got=%b exp=%b", outs(), exp);
      end
      tick();
      exp = mk(0, 0, 0, 0, 1, 6'd0);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t4_err got=%b exp=%b", outs(), exp);
      end
      start_i = 1'b1; num_cuts_i = 6'd1;
      tick();
      start_i = 1'b0;
      repeat (3) tick();
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t4_start_ignored got=%b exp=%b", outs(), exp);
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      exp = mk(0, 0, 0, 0, 0, 6'd0);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t4_abort got=%b exp=%b", outs(), exp);
      end
   endtask

   task automatic test_abort();
      logic [10:0] exp;
      bit ok;
      num_cuts_i = 6'd5; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int r = 0; r < 3; r++) begin
         run_feed(2);
         wait_cut(ok);
         checks++;
         if (!ok) begin
            failures++; $display("FAIL t5_cut_wait r=%0d got=%0b exp=1", r, ok);
         end
         if (r < 2) begin
            stroke();
            exp = mk(1, 0, 1, 0, 0, 6'(r + 1));
            checks++;
            if (outs() !== exp) begin
               failures++; $display("FAIL t5_round r=%0d got=%b exp=%b", r, outs(), exp);
            end
         end
      end
      repeat (5) tick();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      exp = mk(0, 0, 0, 0, 0, 6'd2);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t5_abort got=%b exp=%b", outs(), exp);
      end
      tick();
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t5_no_done got=%b exp=%b", outs(), exp);
      end
      num_cuts_i = 6'd1; start_i = 1'b1;
      tick();
      start_i = 1'b0; num_cuts_i = 6'd7;
      exp = mk(1, 0, 1, 0, 0, 6'd0);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t5_restart got=%b exp=%b", outs(), exp);
      end
      run_feed(2);
      wait_cut(ok);
      stroke();
      exp = mk(0, 0, 1, 1, 0, 6'd1);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t5_restart_done got=%b exp=%b", outs(), exp);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [10:0] exp;
      bit ok;
      num_cuts_i = 6'd2; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      run_feed(2);
      wait_cut(ok);
      stroke();
      run_feed(2);
      start_i = 1'b1; num_cuts_i = 6'd9;
      tick();
      start_i = 1'b0;
      exp = mk(0, 0, 1, 0, 0, 6'd1);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t6_busy_start got=%b exp=%b", outs(), exp);
      end
      rst = 1'b1;
      tick();
      exp = mk(0, 0, 0, 0, 0, 6'd0);
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t6_reset got=%b exp=%b", outs(), exp);
      end
      rst = 1'b0;
      repeat (10) tick();
      checks++;
      if (outs() !== exp) begin
         failures++; $display("FAIL t6_stays_idle got=%b exp=%b", outs(), exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_full_job();
      test_zero_job();
      test_level_cut_end();
      test_timeout();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit");
   end

endmodule
